// File: rtl/barrel_pkg.sv
// -----------------------------------------------------------------------------
// barrel_pkg
//   Shared definitions for the pipelined barrel shifter.
//   - mode_e       : 2-bit shift-mode encoding carried with every beat.
//   - stage_ctrl_t : control fields of one pipeline stage register. The data
//                    and remaining-amount fields depend on WIDTH, so they sit
//                    beside this record inside each stage.
// -----------------------------------------------------------------------------
package barrel_pkg;

  typedef enum logic [1:0] {
    MODE_ROR = 2'b00,  // rotate right
    MODE_ROL = 2'b01,  // rotate left
    MODE_LSR = 2'b10,  // logical shift right, zero fill
    MODE_ASR = 2'b11   // arithmetic shift right, sign fill
  } mode_e;

  typedef struct packed {
    logic  valid;  // stage holds a live beat
    logic  sign;   // MSB of the original operand, used as ASR fill
    mode_e mode;   // mode of the beat held in this stage
  } stage_ctrl_t;

endpackage : barrel_pkg

// File: rtl/barrel_stage.sv
// -----------------------------------------------------------------------------
// barrel_stage
//   One stage of the pipelined barrel shifter. Shifts the incoming operand by
//   STEP positions when amount bit log2(STEP) is set, otherwise passes it
//   through, and registers the result together with its control fields.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   i_valid           : upstream beat present
//   i_ready           : downstream can take this stage's beat on this edge
//   i_data/i_amt      : operand and full shift amount
//   i_mode/i_sign     : shift mode and original operand MSB
//   o_valid           : this stage holds a beat
//   o_data/o_amt      : registered result and amount
//   o_mode/o_sign     : registered mode and sign
// -----------------------------------------------------------------------------
module barrel_stage
  import barrel_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int STEP  = 1,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic             i_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [AMT_W-1:0] i_amt,
  input  logic [1:0]       i_mode,
  input  logic             i_sign,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [AMT_W-1:0] o_amt,
  output logic [1:0]       o_mode,
  output logic             o_sign
);

  // Amount bit that selects this stage's shift.
  localparam int BIT = $clog2(STEP);
  // Top STEP bits set: the positions vacated by a right shift.
  localparam logic [WIDTH-1:0] FILL_MASK = ~({WIDTH{1'b1}} >> STEP);

  stage_ctrl_t      r_ctrl;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_amt;

  logic [WIDTH-1:0] w_shifted;
  logic             w_load;

  // Bubble collapse: an empty stage always loads, a full one loads only when
  // its beat is leaving on the same edge.
  assign w_load = !r_ctrl.valid || i_ready;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_shifted = i_data;
    if (i_amt[BIT]) begin
      case (mode_e'(i_mode))
        MODE_ROR: w_shifted = (i_data >> STEP) | (i_data << (WIDTH - STEP));
        MODE_ROL: w_shifted = (i_data << STEP) | (i_data >> (WIDTH - STEP));
        MODE_LSR: w_shifted = i_data >> STEP;
        MODE_ASR: w_shifted = (i_data >> STEP) | (i_sign ? FILL_MASK : '0);
        default:  w_shifted = i_data;
      endcase
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every stage
  // samples its neighbour's pre-edge value, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: payload registers are cleared too, not just valid, so the
      // output bus reads a defined 0 right after reset.
      r_ctrl <= '{valid: 1'b0, sign: 1'b0, mode: MODE_ROR};
      r_data <= '0;
      r_amt  <= '0;
    end else if (w_load) begin
      r_ctrl.valid <= i_valid;
      // Payload only moves with a real beat; while stalled w_load is low, so
      // the held beat stays stable on the outputs.
      if (i_valid) begin
        r_ctrl.sign <= i_sign;
        r_ctrl.mode <= mode_e'(i_mode);
        r_data      <= w_shifted;
        r_amt       <= i_amt;
      end
    end
  end

  assign o_valid = r_ctrl.valid;
  assign o_data  = r_data;
  assign o_amt   = r_amt;
  assign o_mode  = r_ctrl.mode;
  assign o_sign  = r_ctrl.sign;

endmodule : barrel_stage

// File: rtl/barrel_shifter_pipe.sv
// -----------------------------------------------------------------------------
// barrel_shifter_pipe
//   Pipelined barrel shifter with valid/ready on both sides. Stage k shifts by
//   2^k when amount bit k is set; log2(WIDTH) stages in total, one result per
//   clock when the consumer keeps out_ready high.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake
//   in_data             : WIDTH-bit operand
//   in_amt              : shift amount 0..WIDTH-1
//   in_mode             : 00 ROR, 01 ROL, 10 LSR, 11 ASR
//   out_valid/out_ready : output handshake
//   out_data            : shifted result
//   out_mode            : mode of the result beat
// -----------------------------------------------------------------------------
module barrel_shifter_pipe
  import barrel_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode
);

  // Index 0 is the input beat, index k+1 is the register of stage k.
  logic [AMT_W:0]            w_valid;
  logic [AMT_W:0][WIDTH-1:0] w_data;
  logic [AMT_W:0][AMT_W-1:0] w_amt;
  logic [AMT_W:0][1:0]       w_mode;
  logic [AMT_W:0]            w_sign;

  // w_dn_ready[k]: the beat in stage k may leave on this edge.
  logic [AMT_W-1:0]          w_dn_ready;

  assign w_valid[0] = in_valid;
  assign w_data[0]  = in_data;
  assign w_amt[0]   = in_amt;
  assign w_mode[0]  = in_mode;
  assign w_sign[0]  = in_data[WIDTH-1];

  // Backpressure chain derived from the registered valid bits and out_ready
  // only, so in_ready never depends on in_valid. Stage k+1 can take stage k's
  // beat when it is empty or its own beat is leaving.
  always_comb begin
    w_dn_ready = '0;
    w_dn_ready[AMT_W-1] = out_ready;
    for (int k = AMT_W - 2; k >= 0; k--) begin
      w_dn_ready[k] = !w_valid[k+2] || w_dn_ready[k+1];
    end
  end

  assign in_ready = !w_valid[1] || w_dn_ready[0];

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    barrel_stage #(
      .WIDTH (WIDTH),
      .STEP  (1 << k)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .i_valid (w_valid[k]),
      .i_ready (w_dn_ready[k]),
      .i_data  (w_data[k]),
      .i_amt   (w_amt[k]),
      .i_mode  (w_mode[k]),
      .i_sign  (w_sign[k]),
      .o_valid (w_valid[k+1]),
      .o_data  (w_data[k+1]),
      .o_amt   (w_amt[k+1]),
      .o_mode  (w_mode[k+1]),
      .o_sign  (w_sign[k+1])
    );
  end

  assign out_valid = w_valid[AMT_W];
  assign out_data  = w_data[AMT_W];
  assign out_mode  = w_mode[AMT_W];

  // Amount and sign of the last stage have no consumer; they exist only
  // because every stage is built from the same module.
  logic w_unused_tail;
  assign w_unused_tail = ^{w_amt[AMT_W], w_sign[AMT_W]};

endmodule : barrel_shifter_pipe

// File: tb/tb_barrel_shifter_pipe.sv
module tb_barrel_shifter_pipe;
  import barrel_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 8-bit instance
  logic        v8, r8, ov8, ordy8;
  logic [7:0]  d8, od8;
  logic [2:0]  a8;
  logic [1:0]  m8, om8;
  logic [63:0] e8;

  // 32-bit instance
  logic        v32, r32, ov32, ordy32;
  logic [31:0] d32, od32;
  logic [4:0]  a32;
  logic [1:0]  m32, om32;
  logic [63:0] e32;

  barrel_shifter_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(v8), .in_ready(r8), .in_data(d8), .in_amt(a8), .in_mode(m8),
    .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .out_mode(om8)
  );

  barrel_shifter_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset),
    .in_valid(v32), .in_ready(r32), .in_data(d32), .in_amt(a32), .in_mode(m32),
    .out_valid(ov32), .out_ready(ordy32), .out_data(od32), .out_mode(om32)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  mode;
    int          cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];

  logic        chk_lat   = 1'b0;
  logic        chk_rdy8  = 1'b0;
  logic        stall8_q  = 1'b0;
  logic        stall32_q = 1'b0;
  logic [7:0]  hold8_d;
  logic [1:0]  hold8_m;
  logic [31:0] hold32_d;
  logic [1:0]  hold32_m;
  int          acc8 = 0, acc32 = 0, got8 = 0;

  // Bitwise reference: output bit i takes the operand bit it came from.
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int amt,
                                            input logic [1:0] mode, input int w);
    logic [63:0] r;
    logic        s;
    r = '0;
    s = d[w-1];
    for (int i = 0; i < w; i++) begin
      case (mode)
        2'b00:   r[i] = d[(i + amt) % w];
        2'b01:   r[i] = d[(i - amt + w) % w];
        2'b10:   r[i] = (i + amt < w) ? d[i + amt] : 1'b0;
        default: r[i] = (i + amt < w) ? d[i + amt] : s;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive8(input logic v, input logic [7:0] d, input logic [2:0] a,
                        input logic [1:0] m, input logic [63:0] e);
    v8 = v; d8 = d; a8 = a; m8 = m; e8 = e;
  endtask

  task automatic drive32(input logic v, input logic [31:0] d, input logic [4:0] a,
                         input logic [1:0] m, input logic [63:0] e);
    v32 = v; d32 = d; a32 = a; m32 = m; e32 = e;
  endtask

  // Score the handshakes that happen on the coming rising edge.
  task automatic eval8();
    exp_t e;
    if (stall8_q) begin
      check("stall8_data", 64'(od8), 64'(hold8_d));
      check("stall8_mode", 64'(om8), 64'(hold8_m));
    end
    if (chk_rdy8) check("stream_in_ready8", 64'(r8), 64'd1);
    if (ov8 && ordy8) begin
      if (q8.size() == 0) begin
        check("spurious_out8", 64'(ov8), 64'd0);
      end else begin
        e = q8.pop_front();
        check("data8", 64'(od8), e.data);
        check("mode8", 64'(om8), 64'(e.mode));
        if (chk_lat) check("latency8", 64'(cyc - e.cyc), 64'd3);
        got8++;
      end
    end
    if (v8 && r8) begin
      q8.push_back('{data: e8, mode: m8, cyc: cyc});
      acc8++;
    end
    stall8_q = ov8 && !ordy8;
    hold8_d  = od8;
    hold8_m  = om8;
  endtask

  task automatic eval32();
    exp_t e;
    if (stall32_q) begin
      check("stall32_data", 64'(od32), 64'(hold32_d));
      check("stall32_mode", 64'(om32), 64'(hold32_m));
    end
    if (ov32 && ordy32) begin
      if (q32.size() == 0) begin
        check("spurious_out32", 64'(ov32), 64'd0);
      end else begin
        e = q32.pop_front();
        check("data32", 64'(od32), e.data);
        check("mode32", 64'(om32), 64'(e.mode));
      end
    end
    if (v32 && r32) begin
      q32.push_back('{data: e32, mode: m32, cyc: cyc});
      acc32++;
    end
    stall32_q = ov32 && !ordy32;
    hold32_d  = od32;
    hold32_m  = om32;
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic go();
    #1;
    eval8();
    eval32();
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    drive8(1'b0, 8'h00, 3'd0, 2'b00, 64'h0);
    drive32(1'b0, 32'h0, 5'd0, 2'b00, 64'h0);
    ordy8  = 1'b1;
    ordy32 = 1'b1;
    for (int i = 0; i < budget && (q8.size() != 0 || q32.size() != 0); i++) go();
    check("drain_q8_empty", 64'(q8.size()), 64'd0);
    check("drain_q32_empty", 64'(q32.size()), 64'd0);
  endtask

  // Directed vectors: data, amt, mode, hand-computed result.
  logic [7:0]  dv_d [16] = '{8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1,
                             8'h01, 8'h80, 8'h80, 8'h80, 8'h7F, 8'h81, 8'hC3, 8'hC3};
  logic [2:0]  dv_a [16] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0,
                             3'd7, 3'd7, 3'd7, 3'd1, 3'd7, 3'd4, 3'd5, 3'd2};
  logic [1:0]  dv_m [16] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11,
                             2'b00, 2'b11, 2'b10, 2'b01, 2'b11, 2'b01, 2'b00, 2'b11};
  logic [63:0] dv_e [16] = '{64'h36, 64'h8D, 64'h16, 64'hF6, 64'hB1, 64'hB1, 64'hB1, 64'hB1,
                             64'h02, 64'hFF, 64'h01, 64'h01, 64'h00, 64'h18, 64'h1E, 64'hF0};

  // Stall beats, all ROL by 2.
  logic [7:0]  st_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [63:0] st_e [4] = '{64'h44, 64'h88, 64'hCC, 64'h11};

  initial begin
    int          base, base32, k, got_base;
    logic [7:0]  rd8;
    logic [2:0]  ra8;
    logic [1:0]  rm8;
    logic [31:0] rd32;
    logic [4:0]  ra32;
    logic [1:0]  rm32;

    reset = 1'b1;
    drive8(1'b0, 8'h00, 3'd0, 2'b00, 64'h0);
    drive32(1'b0, 32'h0, 5'd0, 2'b00, 64'h0);
    ordy8  = 1'b1;
    ordy32 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_out_valid8", 64'(ov8), 64'd0);
    check("reset_out_data8", 64'(od8), 64'd0);
    check("reset_out_mode8", 64'(om8), 64'd0);
    check("reset_in_ready8", 64'(r8), 64'd1);
    check("reset_out_valid32", 64'(ov32), 64'd0);
    check("reset_in_ready32", 64'(r32), 64'd1);
    @(negedge clk);

    // Directed vectors back to back, unstalled: latency and order checked.
    chk_lat = 1'b1;
    base = acc8;
    for (int i = 0; i < 16; i++) begin
      drive8(1'b1, dv_d[i], dv_a[i], dv_m[i], dv_e[i]);
      go();
    end
    check("directed_accepted", 64'(acc8 - base), 64'd16);
    drain(20);

    // 64-beat random stream with out_ready high.
    chk_rdy8 = 1'b1;
    base = acc8;
    for (int i = 0; i < 64; i++) begin
      rd8 = 8'($urandom());
      ra8 = 3'($urandom());
      rm8 = 2'($urandom());
      drive8(1'b1, rd8, ra8, rm8, ref_shift(64'(rd8), int'(ra8), rm8, 8));
      go();
    end
    chk_rdy8 = 1'b0;
    check("stream_accepted", 64'(acc8 - base), 64'd64);
    drain(20);

    // Stall: out_ready low for 6 cycles with in_valid held high.
    chk_lat  = 1'b0;
    ordy8    = 1'b0;
    base     = acc8;
    got_base = got8;
    for (int i = 0; i < 6; i++) begin
      k = acc8 - base;
      if (k > 3) k = 3;
      drive8(1'b1, st_d[k], 3'd2, 2'b01, st_e[k]);
      go();
    end
    check("stall_accepted", 64'(acc8 - base), 64'd3);
    check("stall_in_ready", 64'(r8), 64'd0);
    check("stall_out_valid", 64'(ov8), 64'd1);
    // Release: in_ready follows out_ready in the same cycle; accept and drain
    // share this edge.
    ordy8 = 1'b1;
    drive8(1'b1, st_d[3], 3'd2, 2'b01, st_e[3]);
    #1;
    check("release_in_ready", 64'(r8), 64'd1);
    go();
    drain(20);
    check("stall_all_drained", 64'(got8 - got_base), 64'd4);

    // Random valid/ready toggling on both widths.
    base   = acc8;
    base32 = acc32;
    for (int c = 0; c < 12000 && ((acc8 - base) < 1000 || (acc32 - base32) < 1000); c++) begin
      ordy8  = 1'($urandom_range(0, 1));
      ordy32 = 1'($urandom_range(0, 1));
      rd8  = 8'($urandom());
      ra8  = 3'($urandom());
      rm8  = 2'($urandom());
      rd32 = $urandom();
      ra32 = 5'($urandom());
      rm32 = 2'($urandom());
      drive8(((acc8 - base) < 1000) ? 1'($urandom_range(0, 1)) : 1'b0,
             rd8, ra8, rm8, ref_shift(64'(rd8), int'(ra8), rm8, 8));
      drive32(((acc32 - base32) < 1000) ? 1'($urandom_range(0, 1)) : 1'b0,
              rd32, ra32, rm32, ref_shift(64'(rd32), int'(ra32), rm32, 32));
      go();
    end
    check("random_accepted8", 64'(acc8 - base), 64'd1000);
    check("random_accepted32", 64'(acc32 - base32), 64'd1000);
    drain(40);

    // Reset with two beats in flight, plus a beat offered on the reset edge.
    ordy8 = 1'b0;
    drive8(1'b1, 8'h5A, 3'd1, 2'b00, 64'h2D);
    go();
    drive8(1'b1, 8'hA5, 3'd1, 2'b10, 64'h52);
    go();
    reset = 1'b1;
    drive8(1'b1, 8'hFF, 3'd0, 2'b00, 64'hFF);
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(ov8), 64'd0);
    check("midrst_out_data", 64'(od8), 64'd0);
    check("midrst_out_mode", 64'(om8), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive8(1'b0, 8'h00, 3'd0, 2'b00, 64'h0);
    ordy8 = 1'b1;
    q8.delete();
    q32.delete();
    stall8_q  = 1'b0;
    stall32_q = 1'b0;
    #1;
    check("midrst_in_ready", 64'(r8), 64'd1);
    @(negedge clk);
    for (int i = 0; i < 8; i++) go();
    check("midrst_no_stale", 64'(ov8), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_barrel_shifter_pipe
